mem_dump_streamer: RTL

//  Downstream consumer of the sample memory during IAGC_STATUS_DUMP_MEM.

---
 rtl/mem_dump_streamer_pkg.sv | 15 +
 rtl/mem_dump_streamer_word_serializer.sv | 42 ++++
 rtl/mem_dump_streamer.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_dump_streamer_pkg.sv
// Shared types and status codes for the sample-memory dump streamer.
package mem_dump_streamer_pkg;

  localparam logic [3:0] IAGC_STATUS_IDLE     = 4'b0000;
  localparam logic [3:0] IAGC_STATUS_DUMP_MEM = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_t;

endpackage

// File: rtl/mem_dump_streamer_word_serializer.sv
// Holds one memory word and presents it MSB byte first on a valid/ready byte port.
module mem_dump_streamer_word_serializer #(
  parameter int DATA_SIZE = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_load,
  input  logic [DATA_SIZE-1:0] i_word,
  input  logic                 i_active,
  input  logic                 i_tx_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_xfer,
  output logic                 o_last_byte
);

  localparam int NUM_BYTES = DATA_SIZE / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [DATA_SIZE-1:0] word_q;
  logic [CNT_W-1:0]     left_q;

  assign o_tx_valid  = i_active;
  assign o_xfer      = i_active & i_tx_ready;
  assign o_last_byte = (left_q == '0);
  assign o_tx_data   = word_q[DATA_SIZE-1 -: 8];

  // Outgoing byte always sits in the top lane; bytes remaining counts down to zero.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      word_q <= '0;
      left_q <= '0;
    end else if (i_load) begin
      word_q <= i_word;
      left_q <= CNT_W'(NUM_BYTES - 1);
    end else if (o_xfer && !o_last_byte) begin
      word_q <= word_q << 8;
      left_q <= left_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_dump_streamer.sv
// Walks sample memory 0..last during DUMP_MEM and streams each word as bytes to the UART.
//  state | meaning
//  IDLE  | waiting for DUMP_MEM; latches clamped last address on entry
//  ADDR  | o_raddr presented, memory updates at the negedge
//  LOAD  | capture memory word into the serializer
//  SEND  | bytes offered on the valid/ready port
//  DONE  | all words sent, o_dump_end held
module mem_dump_streamer
  import mem_dump_streamer_pkg::*;
#(
  parameter int DATA_SIZE        = 16,
  parameter int ADDR_SIZE        = 12,
  parameter int MEMORY_SIZE      = 1024,
  parameter int IAGC_STATUS_SIZE = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
  input  logic [ADDR_SIZE-1:0]        i_last_addr,
  input  logic [DATA_SIZE-1:0]        i_mem_data,
  input  logic                        i_tx_ready,
  output logic [ADDR_SIZE-1:0]        o_raddr,
  output logic [7:0]                  o_tx_data,
  output logic                        o_tx_valid,
  output logic                        o_dump_end
);

  localparam logic [ADDR_SIZE-1:0] MAX_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);

  dump_state_t          state_q, state_d;
  logic [ADDR_SIZE-1:0] raddr_q, last_q;
  logic                 dump_mem;
  logic                 load, active, xfer, last_byte;

  assign dump_mem = (i_iagc_status == IAGC_STATUS_SIZE'(IAGC_STATUS_DUMP_MEM));
  assign o_raddr  = raddr_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!dump_mem) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ADDR;
        ST_ADDR: state_d = ST_LOAD;
        ST_LOAD: state_d = ST_SEND;
        ST_SEND: if (xfer && last_byte) state_d = (raddr_q == last_q) ? ST_DONE : ST_ADDR;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load       = (state_q == ST_LOAD);
    active     = (state_q == ST_SEND);
    o_dump_end = (state_q == ST_DONE);
  end

  // Last address is frozen at dump start so later i_last_addr changes are ignored.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      raddr_q <= '0;
      last_q  <= '0;
    end else if (!dump_mem) begin
      raddr_q <= '0;
    end else if (state_q == ST_IDLE) begin
      raddr_q <= '0;
      last_q  <= (i_last_addr > MAX_ADDR) ? MAX_ADDR : i_last_addr;
    end else if (state_q == ST_SEND && state_d == ST_ADDR) begin
      raddr_q <= raddr_q + ADDR_SIZE'(1);
    end
  end

  mem_dump_streamer_word_serializer #(
    .DATA_SIZE(DATA_SIZE)
  ) u_serializer (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_load     (load),
    .i_word     (i_mem_data),
    .i_active   (active),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_xfer     (xfer),
    .o_last_byte(last_byte)
  );

endmodule
